// File: rtl/banco_registradores_p.sv
// banco_registradores_p: parametrised register file with optional hardwired zero,
// optional write-to-read bypass and a sequential clear sweep that gates use via pronto.
module banco_registradores_p #(
    parameter int LARGURA   = 32,
    parameter int NUM_REGS  = 32,
    parameter int END_BITS  = 5,
    parameter int ZERO_FIXO = 1,
    parameter int BYPASS    = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                limpar,
    input  logic [END_BITS-1:0] end_leitura1,
    input  logic [END_BITS-1:0] end_leitura2,
    input  logic [END_BITS-1:0] end_escrita,
    input  logic                write_reg,
    input  logic [LARGURA-1:0]  dados_escrita,
    output logic [LARGURA-1:0]  read_RS,
    output logic [LARGURA-1:0]  read_RT,
    output logic [LARGURA-1:0]  read_RD,
    output logic                pronto
);

    localparam logic [0:0] LIMPANDO = 1'b0;
    localparam logic [0:0] PRONTO   = 1'b1;

    localparam int                  PROFUNDIDADE = 1 << END_BITS;
    localparam logic [END_BITS-1:0] ULTIMO       = END_BITS'(NUM_REGS - 1);

    // One bit per encodable address: set when the address maps to a real,
    // writable register. Out-of-range and hardwired-zero addresses read as 0.
    function automatic logic [PROFUNDIDADE-1:0] monta_mapa_valido();
        logic [PROFUNDIDADE-1:0] mapa;
        for (int i = 0; i < PROFUNDIDADE; i++) begin
            mapa[i] = (i < NUM_REGS) && !((ZERO_FIXO != 0) && (i == 0));
        end
        return mapa;
    endfunction

    localparam logic [PROFUNDIDADE-1:0] MAPA_VALIDO = monta_mapa_valido();

    function automatic logic [LARGURA-1:0] seleciona(
        input logic               ativo,
        input logic               endereco_ok,
        input logic               desvio,
        input logic [LARGURA-1:0] dado_desvio,
        input logic [LARGURA-1:0] dado_mem
    );
        logic [LARGURA-1:0] resultado;
        resultado = {LARGURA{1'b0}};
        if (ativo && endereco_ok) begin
            if (desvio) begin
                resultado = dado_desvio;
            end else begin
                resultado = dado_mem;
            end
        end else begin
            resultado = {LARGURA{1'b0}};
        end
        return resultado;
    endfunction

    logic [0:0]          estado_r;
    logic [END_BITS-1:0] contador_r;
    logic                pronto_r;
    logic [LARGURA-1:0]  registradores_r [NUM_REGS];

    logic                em_pronto_s;
    logic                escrita_valida_s;
    logic                desvio_ativo_s;
    logic [LARGURA-1:0]  mem_rs_s;
    logic [LARGURA-1:0]  mem_rt_s;
    logic [LARGURA-1:0]  mem_rd_s;

    // Write qualification shared by the array update and the bypass paths.
    always_comb begin
        em_pronto_s      = (estado_r == PRONTO);
        escrita_valida_s = em_pronto_s && write_reg && !limpar && MAPA_VALIDO[end_escrita];
        desvio_ativo_s   = (BYPASS != 0) && escrita_valida_s;
    end

    // Raw array reads; out-of-range addresses are masked by the valid map afterwards.
    always_comb begin
        mem_rs_s = registradores_r[end_leitura1];
        mem_rt_s = registradores_r[end_leitura2];
        mem_rd_s = registradores_r[end_escrita];
    end

    // Read ports: zero while sweeping or for invalid addresses, else bypass or array.
    always_comb begin
        read_RS = seleciona(em_pronto_s, MAPA_VALIDO[end_leitura1],
                            desvio_ativo_s && (end_leitura1 == end_escrita),
                            dados_escrita, mem_rs_s);
        read_RT = seleciona(em_pronto_s, MAPA_VALIDO[end_leitura2],
                            desvio_ativo_s && (end_leitura2 == end_escrita),
                            dados_escrita, mem_rt_s);
        read_RD = seleciona(em_pronto_s, MAPA_VALIDO[end_escrita],
                            desvio_ativo_s, dados_escrita, mem_rd_s);
    end

    assign pronto = pronto_r;

    // Clear-sweep FSM plus array writes; reset restarts the sweep without touching the array.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_r   <= LIMPANDO;
            contador_r <= {END_BITS{1'b0}};
            pronto_r   <= 1'b0;
        end else begin
            case (estado_r)
                LIMPANDO: begin
                    registradores_r[contador_r] <= {LARGURA{1'b0}};
                    if (contador_r == ULTIMO) begin
                        estado_r <= PRONTO;
                        pronto_r <= 1'b1;
                    end else begin
                        contador_r <= contador_r + END_BITS'(1'b1);
                    end
                end
                PRONTO: begin
                    // A clear request wins over a simultaneous write.
                    if (limpar) begin
                        estado_r   <= LIMPANDO;
                        contador_r <= {END_BITS{1'b0}};
                        pronto_r   <= 1'b0;
                    end else if (escrita_valida_s) begin
                        registradores_r[end_escrita] <= dados_escrita;
                    end
                end
                default: begin
                    estado_r   <= LIMPANDO;
                    contador_r <= {END_BITS{1'b0}};
                    pronto_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_banco_registradores_p.sv
// tb_banco_registradores_p: two instances (default, and 20 regs / no zero / no bypass)
// driven in parallel; a queue-based scoreboard checks every cycle against a bank model.
module tb_banco_registradores_p;

    logic        clock = 1'b0;
    logic        reset;
    logic        limpar;
    logic        write_reg;
    logic [4:0]  e1, e2, ew;
    logic [31:0] dados;
    logic [31:0] rs_a, rt_a, rd_a, rs_b, rt_b, rd_b;
    logic        pronto_a, pronto_b;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    banco_registradores_p dut_a (
        .clock(clock), .reset(reset), .limpar(limpar),
        .end_leitura1(e1), .end_leitura2(e2), .end_escrita(ew),
        .write_reg(write_reg), .dados_escrita(dados),
        .read_RS(rs_a), .read_RT(rt_a), .read_RD(rd_a), .pronto(pronto_a)
    );

    banco_registradores_p #(
        .LARGURA(32), .NUM_REGS(20), .END_BITS(5), .ZERO_FIXO(0), .BYPASS(0)
    ) dut_b (
        .clock(clock), .reset(reset), .limpar(limpar),
        .end_leitura1(e1), .end_leitura2(e2), .end_escrita(ew),
        .write_reg(write_reg), .dados_escrita(dados),
        .read_RS(rs_b), .read_RT(rt_b), .read_RD(rd_b), .pronto(pronto_b)
    );

    typedef struct packed {
        logic [31:0] rs_a, rt_a, rd_a, rs_b, rt_b, rd_b;
        logic        pr_a, pr_b;
    } esperado_t;

    esperado_t fila[$];

    // Reference model: abstract bank contents, a ready flag and a countdown of sweep edges.
    logic [31:0] mem [2][32];
    int          restantes [2];
    bit          pronto_m [2];

    function automatic int nr(int k);
        return (k == 0) ? 32 : 20;
    endfunction

    function automatic bit zf(int k);
        return (k == 0);
    endfunction

    function automatic bit bp(int k);
        return (k == 0);
    endfunction

    function automatic bit end_ok(int k, int a);
        return (a < nr(k)) && !(zf(k) && a == 0);
    endfunction

    function automatic bit escrita_ok(int k);
        return pronto_m[k] && write_reg && !limpar && end_ok(k, int'(ew));
    endfunction

    function automatic logic [31:0] le(int k, int a);
        if (!pronto_m[k] || !end_ok(k, a)) return 32'h0;
        if (bp(k) && escrita_ok(k) && a == int'(ew)) return dados;
        return mem[k][a];
    endfunction

    task automatic atualiza_modelo();
        for (int k = 0; k < 2; k++) begin
            bit wk;
            wk = escrita_ok(k);
            if (reset || (pronto_m[k] && limpar)) begin
                pronto_m[k]  = 1'b0;
                restantes[k] = nr(k);
                for (int j = 0; j < 32; j++) mem[k][j] = 32'h0;
            end else if (!pronto_m[k]) begin
                restantes[k]--;
                if (restantes[k] == 0) pronto_m[k] = 1'b1;
            end else if (wk) begin
                mem[k][ew] = dados;
            end
        end
    endtask

    // Push the expectation for the current inputs, then take one clock edge.
    task automatic passo(input logic r, input logic l, input logic w,
                         input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] aw, input logic [31:0] d);
        esperado_t e;
        reset = r; limpar = l; write_reg = w;
        e1 = a1; e2 = a2; ew = aw; dados = d;
        e.rs_a = le(0, int'(a1)); e.rt_a = le(0, int'(a2)); e.rd_a = le(0, int'(aw));
        e.rs_b = le(1, int'(a1)); e.rt_b = le(1, int'(a2)); e.rd_b = le(1, int'(aw));
        e.pr_a = pronto_m[0];     e.pr_b = pronto_m[1];
        fila.push_back(e);
        @(posedge clock);
        atualiza_modelo();
        #1;
    endtask

    task automatic compara(input string nome, input logic [31:0] obtido, input logic [31:0] req);
        checks++;
        if (obtido !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nome, obtido, req, $time);
        end
    endtask

    // Monitor: one expectation per cycle, compared away from the active edge.
    always @(negedge clock) begin : monitor
        esperado_t e;
        if (fila.size() > 0) begin
            e = fila.pop_front();
            compara("rs_a", rs_a, e.rs_a);
            compara("rt_a", rt_a, e.rt_a);
            compara("rd_a", rd_a, e.rd_a);
            compara("pronto_a", {31'h0, pronto_a}, {31'h0, e.pr_a});
            compara("rs_b", rs_b, e.rs_b);
            compara("rt_b", rt_b, e.rt_b);
            compara("rd_b", rd_b, e.rd_b);
            compara("pronto_b", {31'h0, pronto_b}, {31'h0, e.pr_b});
        end
    end

    initial begin
        reset = 1'b1; limpar = 1'b0; write_reg = 1'b1;
        e1 = 5'd0; e2 = 5'd0; ew = 5'd1; dados = 32'h1111_1111;
        for (int k = 0; k < 2; k++) pronto_m[k] = 1'b0;
        // First reset edge: DUT state is unknown before it, so nothing is queued.
        @(posedge clock);
        atualiza_modelo();
        #1;
        passo(1'b1, 1'b0, 1'b1, 5'd2, 5'd3, 5'd2, 32'h2222_2222);

        // Sweep after release: pronto low for exactly NUM_REGS edges.
        for (int i = 0; i < 34; i++)
            passo(1'b0, 1'b0, 1'b0, 5'(i), 5'(31 - i), 5'(i), 32'h0);
        for (int i = 0; i < 32; i++)
            passo(1'b0, 1'b0, 1'b0, 5'(i), 5'(31 - i), 5'(i), 32'h0);

        // Write with bypass, then a plain read.
        passo(1'b0, 1'b0, 1'b1, 5'd9, 5'd9, 5'd9, 32'hDEAD_BEEF);
        passo(1'b0, 1'b0, 1'b0, 5'd9, 5'd9, 5'd0, 32'h0);

        // Write to address 0: hardwired zero on instance a, real register on b.
        passo(1'b0, 1'b0, 1'b1, 5'd0, 5'd9, 5'd0, 32'h1234_5678);
        passo(1'b0, 1'b0, 1'b0, 5'd0, 5'd9, 5'd0, 32'h0);

        // Clear wins over a simultaneous write.
        passo(1'b0, 1'b0, 1'b1, 5'd3, 5'd4, 5'd3, 32'h0000_00A5);
        passo(1'b0, 1'b1, 1'b1, 5'd3, 5'd4, 5'd4, 32'h0000_00FF);
        for (int i = 0; i < 33; i++)
            passo(1'b0, 1'b0, 1'b0, 5'd3, 5'd4, 5'd9, 32'h0);

        // Reset at sweep edge 10 with write_reg held high.
        passo(1'b0, 1'b1, 1'b0, 5'd3, 5'd4, 5'd3, 32'h0);
        for (int i = 0; i < 9; i++)
            passo(1'b0, 1'b0, 1'b1, 5'd5, 5'd6, 5'd5, 32'hCAFE_0000 + 32'(i));
        passo(1'b1, 1'b0, 1'b1, 5'd5, 5'd6, 5'd5, 32'hBAD0_BAD0);
        for (int i = 0; i < 33; i++)
            passo(1'b0, 1'b0, 1'b1, 5'(i), 5'd5, 5'(i), 32'hFACE_0000 + 32'(i));

        // Address beyond NUM_REGS on instance b.
        passo(1'b0, 1'b0, 1'b1, 5'd25, 5'd25, 5'd25, 32'h0BAD_F00D);
        passo(1'b0, 1'b0, 1'b0, 5'd25, 5'd19, 5'd25, 32'h0);

        // Randomised traffic with rare clears and resets.
        for (int i = 0; i < 400; i++) begin
            logic        r, l, w;
            logic [4:0]  a1, a2, aw;
            r  = ($urandom_range(199) == 0);
            l  = ($urandom_range(49) == 0);
            w  = ($urandom_range(1) == 1);
            aw = 5'($urandom_range(31));
            a1 = ($urandom_range(3) == 0) ? aw : 5'($urandom_range(31));
            a2 = ($urandom_range(3) == 0) ? aw : 5'($urandom_range(31));
            passo(r, l, w, a1, a2, aw, $urandom);
        end

        @(negedge clock);
        #1;
        checks++;
        if (fila.size() != 0) begin
            errors++;
            $display("FAIL fila_vazia: got %0d pending expected 0", fila.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
